// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and optional skid entry.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
    output logic [15:0]       stall_cycles,
    output logic [7:0]        flush_count,
`endif
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              ready_q;
    logic              accept;
    logic              consume;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = state;
    assign consume   = out_valid & out_ready;
    assign in_ready  = (SKID != 0) ? ready_q : (!out_valid | out_ready);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept)
                        state_nx = ONE;
                end
                ONE: begin
                    if (accept && !consume && SKID != 0)
                        state_nx = FULL;
                    else if (!accept && consume)
                        state_nx = EMPTY;
                end
                FULL: begin
                    if (consume)
                        state_nx = ONE;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // main_ctrl is zeroed whenever the stage drains so bubbles carry no enables
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != FULL);
            if (flush) begin
                main_ctrl <= '0;
                skid_ctrl <= '0;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_data <= in_data;
                            main_ctrl <= in_ctrl;
                        end
                    end
                    ONE: begin
                        if (accept && consume) begin
                            main_data <= in_data;
                            main_ctrl <= in_ctrl;
                        end else if (accept) begin
                            skid_data <= in_data;
                            skid_ctrl <= in_ctrl;
                        end else if (consume) begin
                            main_ctrl <= '0;
                        end
                    end
                    FULL: begin
                        if (consume) begin
                            main_data <= skid_data;
                            main_ctrl <= skid_ctrl;
                            skid_ctrl <= '0;
                        end
                    end
                    default: begin
                        main_ctrl <= '0;
                        skid_ctrl <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (flush && flush_count != 8'hFF)
                flush_count <= flush_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus.
// Each instance has a queue model; a negedge monitor compares state and head item.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  c;
    } item_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic [7:0]  in_ctrl;
    logic        flush;
    logic        out_ready;

    logic        r1, v1, r0, v0;
    logic [15:0] d1, d0;
    logic [7:0]  c1, c0;
    logic [1:0]  o1, o0;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] st1, st0;
    logic [7:0]  fc1, fc0;
    logic [15:0] stall_exp;
    logic [7:0]  flush_exp;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    item_t q1[$];
    item_t q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(r1),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(v1), .out_ready(out_ready),
        .out_data(d1), .out_ctrl(c1),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cycles(st1), .flush_count(fc1),
`endif
        .occupancy(o1)
    );

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(0)) u0 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(r0),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(v0), .out_ready(out_ready),
        .out_data(d0), .out_ctrl(c0),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cycles(st0), .flush_count(fc0),
`endif
        .occupancy(o0)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model for SKID=1: capacity 2, in_ready reflects occupancy after last edge.
    always @(negedge clk) begin
        logic  rdy;
        logic  had;
        item_t it;
        if (!reset_n) begin
            q1.delete();
`ifdef PIPE_STAGE_PERF_EN
            stall_exp = '0;
            flush_exp = '0;
`endif
        end else begin
            rdy = (q1.size() < 2);
            had = (q1.size() != 0);
            chk("u1_occupancy", {30'd0, o1}, q1.size());
            chk("u1_in_ready", {31'd0, r1}, {31'd0, rdy});
            chk("u1_out_valid", {31'd0, v1}, {31'd0, had});
            if (!had) begin
                chk("u1_bubble_ctrl", {24'd0, c1}, 32'd0);
            end else begin
                it = q1[0];
                chk("u1_head_data", {16'd0, d1}, {16'd0, it.d});
                chk("u1_head_ctrl", {24'd0, c1}, {24'd0, it.c});
            end
`ifdef PIPE_STAGE_PERF_EN
            chk("u1_stall_cycles", {16'd0, st1}, {16'd0, stall_exp});
            chk("u1_flush_count", {24'd0, fc1}, {24'd0, flush_exp});
            if (had && !out_ready && stall_exp != 16'hFFFF)
                stall_exp = stall_exp + 16'd1;
            if (flush && flush_exp != 8'hFF)
                flush_exp = flush_exp + 8'd1;
`endif
            if (had && out_ready)
                void'(q1.pop_front());
            if (flush)
                q1.delete();
            else if (in_valid && rdy)
                q1.push_back('{d: in_data, c: in_ctrl});
        end
    end

    // Model for SKID=0: capacity 1, may accept when empty or draining.
    always @(negedge clk) begin
        logic  rdy;
        logic  had;
        item_t it;
        if (!reset_n) begin
            q0.delete();
        end else begin
            had = (q0.size() != 0);
            rdy = !had || out_ready;
            chk("u0_occupancy", {30'd0, o0}, q0.size());
            chk("u0_in_ready", {31'd0, r0}, {31'd0, rdy});
            chk("u0_out_valid", {31'd0, v0}, {31'd0, had});
            if (!had) begin
                chk("u0_bubble_ctrl", {24'd0, c0}, 32'd0);
            end else begin
                it = q0[0];
                chk("u0_head_data", {16'd0, d0}, {16'd0, it.d});
                chk("u0_head_ctrl", {24'd0, c0}, {24'd0, it.c});
            end
            if (had && out_ready)
                void'(q0.pop_front());
            if (flush)
                q0.delete();
            else if (in_valid && rdy)
                q0.push_back('{d: in_data, c: in_ctrl});
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        in_ctrl   = 8'h5A;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, v1}, 32'd0);
        chk("rst_out_ctrl", {24'd0, c1}, 32'd0);
        chk("rst_out_data", {16'd0, d1}, 32'd0);
        chk("rst_in_ready", {31'd0, r1}, 32'd1);
        chk("rst_occupancy", {30'd0, o1}, 32'd0);
        chk("rst_u0_valid", {31'd0, v0}, 32'd0);
        reset_n = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("first_valid", {31'd0, v1}, 32'd1);
        chk("first_data", {16'd0, d1}, 32'h0000BEEF);
        chk("first_ctrl", {24'd0, c1}, 32'h5A);

        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(k);
            in_ctrl  = 8'h81;
            tick();
            chk("stream_in_ready", {31'd0, r1}, 32'd1);
            chk("stream_data", {16'd0, d1}, k);
        end

        in_data = 16'h0003;
        tick();
        out_ready = 1'b0;
        in_data   = 16'h0004;
        tick();
        in_data = 16'h0005;
        chk("bp_occupancy", {30'd0, o1}, 32'd2);
        chk("bp_in_ready", {31'd0, r1}, 32'd0);
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        chk("bp_second", {16'd0, d1}, 32'h0004);
        tick();
        chk("bp_ready_back", {31'd0, r1}, 32'd1);
        chk("bp_drained", {31'd0, v1}, 32'd0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0021;
        tick();
        in_data = 16'h0022;
        tick();
        chk("fl_full", {30'd0, o1}, 32'd2);
        flush     = 1'b1;
        in_data   = 16'h0099;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, v1}, 32'd0);
        chk("fl_ctrl", {24'd0, c1}, 32'd0);
        chk("fl_occ", {30'd0, o1}, 32'd0);
        chk("fl_ready", {31'd0, r1}, 32'd1);
        chk("fl_u0_valid", {31'd0, v0}, 32'd0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0031;
        tick();
        chk("s0_ready_low", {31'd0, r0}, 32'd0);
        out_ready = 1'b1;
        in_data   = 16'h0032;
        #1;
        chk("s0_ready_comb", {31'd0, r0}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("s0_no_bubble", {31'd0, v0}, 32'd1);
        chk("s0_replaced", {16'd0, d0}, 32'h0032);

        for (int i = 0; i < 2000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            in_ctrl   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            if (i == 1000) begin
                #2;
                reset_n = 1'b0;
                #1;
                chk("async_rst_valid", {31'd0, v1}, 32'd0);
                chk("async_rst_occ", {30'd0, o1}, 32'd0);
                chk("async_rst_ready", {31'd0, r1}, 32'd1);
                tick();
                reset_n = 1'b1;
            end
            tick();
        end

`ifdef PIPE_STAGE_PERF_EN
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (70000) tick();
        chk("stall_sat", {16'd0, st1}, 32'h0000FFFF);
        reset_n = 1'b0;
        #1;
        chk("stall_rst", {16'd0, st1}, 32'd0);
        chk("flush_rst", {24'd0, fc1}, 32'd0);
        tick();
        reset_n = 1'b1;
`endif

        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("drain_u1", q1.size(), 32'd0);
        chk("drain_u0", q0.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register. It is the successor to the fixed-field stage registers between IF/ID/EX/MEM/WB. It carries an opaque data bundle plus a control bundle across one stage, with a valid/ready handshake, flush, and an optional 2-entry skid buffer so that upstream ready is registered. Existing stage registers become instances with the bundle widths set.

Parameters:
DATA_W, 16, width of data bundle (operands, addresses); held, not cleared, on bubble.
CTRL_W, 8, width of control bundle (WB/MEM/EX enables, ALU op); forced to 0 whenever stage is empty.
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream offers an item
in_ready  output  1  stage can accept an item
in_data  input  DATA_W  upstream data bundle
in_ctrl  input  CTRL_W  upstream control bundle
flush  input  1  synchronous kill of all held items
out_valid  output  1  stage holds a valid item
out_ready  input  1  downstream accepts the item
out_data  output  DATA_W  held data bundle
out_ctrl  output  CTRL_W  held control bundle, 0 when out_valid=0
occupancy  output  2  items held (0..2; max 1 when SKID=0)

Behaviour:
- Reset (reset_n low, takes effect immediately, asynchronously): out_valid=0, out_data=0, out_ctrl=0, skid entry invalid and zeroed, occupancy=0, in_ready=1. Reset mid-transfer discards all items.
- Transfer rules: input transfer when in_valid&in_ready at a rising edge; output transfer when out_valid&out_ready at a rising edge.
- Latency: an item accepted at edge N appears on out_* after edge N (1 cycle). Order is preserved; no item is lost or duplicated.
- SKID=1 states: EMPTY(0), ONE(1, main valid), FULL(2, main+skid valid). in_ready is a flop: 1 iff the next state != FULL.
  - EMPTY: accept -> ONE, main<=in.
  - ONE: accept & consume -> ONE, main<=in. Accept only -> FULL, skid<=in. Consume only -> EMPTY. Neither -> ONE.
  - FULL: consume -> ONE, main<=skid, skid invalidated. No consume -> FULL. in_ready=0, so no accept occurs.
- SKID=0: in_ready = !out_valid | out_ready (combinational path from out_ready). States EMPTY/ONE only; accept with simultaneous consume replaces main in the same edge.
- Flush, highest priority after reset:
  - At the edge where flush=1, next state = EMPTY, out_valid=0, out_ctrl=0, skid invalidated, occupancy=0.
  - An input handshake completing in the flush cycle is discarded.
  - An output handshake in the flush cycle still counts as consumed downstream.
  - in_ready=1 the cycle after flush.
- out_ctrl is 0 in every cycle where out_valid=0 (bubble). out_data keeps its last value when empty and is not zeroed except by reset.
- out_data/out_ctrl stay stable while out_valid=1 and out_ready=0.
- in_* inputs are sampled only on an accept edge; values while in_valid=0 are don't-care.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds output stall_cycles[15:0], counting cycles with out_valid=1 & out_ready=0, and output flush_count[7:0], counting flush=1 edges.
  - Both counters saturate at all-ones and do not wrap.
  - Both are cleared by reset_n and are unaffected by flush.
- Undefined: neither port nor any counter logic exists. Datapath behaviour is identical in both builds.

Test Plan:
1. Reset: hold reset_n=0 with in_valid=1, in_data=16'hBEEF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0. Release reset -> first accept of 16'hBEEF/ctrl 8'h5A appears 1 cycle later.
2. Streaming: out_ready=1, feed 0x0001..0x0010 back-to-back with ctrl=8'h81 -> same sequence on out_data, one item per cycle, 1-cycle latency, in_ready stays 1.
3. Backpressure (SKID=1): drop out_ready after item 0x0003 is accepted.
   - 0x0004 goes to skid, occupancy=2, in_ready=0 on the following cycle.
   - Raise out_ready -> 0x0003 then 0x0004 delivered in order, in_ready returns to 1.
4. Flush with FULL stage plus an incoming handshake of 0x0099 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0x0099 never appears. With PIPE_STAGE_PERF_EN, flush_count increments by 1.
5. SKID=0: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. Set out_ready=1 with in_valid=1 -> item replaced in one edge, no bubble.
6. PIPE_STAGE_PERF_EN: stall for 70000 cycles -> stall_cycles=16'hFFFF and holds. Reset -> 0.
